action_scheduler: RTL and testbench

- Arbitrates trade-trigger requests from NUM_REQ strategy/risk lanes onto the single GPIO action pulse channel.
- Issues one 1-cycle trigger, with data and source ID, to the downstream pulse generator.
- Enforces a busy window covering the pulse duration plus a configurable guard gap, so no trigger is lost while the pulse channel is active.
- Sits between the per-lane risk gates and the GPIO pulse output.

---
 rtl/action_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/action_scheduler.sv | 101 ++++++++++
 tb/tb_action_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/action_pkg.sv
// Shared types and constants for the GPIO action scheduler.
package action_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam int HOLD_CNT_W          = 10;
  localparam int DEFAULT_PULSE_WIDTH = 10;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request scanning upward from rr_ptr, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [SRC_W-1:0]   grant_idx,
  output logic               any_req,
  output logic               multi_req
);

  logic [SRC_W:0]   scan;
  logic [SRC_W-1:0] idx;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    scan      = '0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = {1'b0, rr_ptr} + (SRC_W+1)'(i);
      if (scan >= (SRC_W+1)'(NUM_REQ)) scan = scan - (SRC_W+1)'(NUM_REQ);
      idx = scan[SRC_W-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  assign any_req   = |req;
  assign multi_req = ($countones(req) > 1);

endmodule

// File: rtl/action_scheduler.sv
// Arbitrates lane trigger requests onto the single GPIO pulse channel, holding off new
// grants for the pulse width plus a guard gap after each trigger.
module action_scheduler
  import action_pkg::*;
#(
  parameter int NUM_REQ             = 4,
  parameter int DATA_W              = 16,
  parameter int PULSE_WIDTH_DEFAULT = DEFAULT_PULSE_WIDTH,
  parameter int SRC_W               = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      act_valid,
  output logic [DATA_W-1:0]         act_data,
  output logic [SRC_W-1:0]          act_src,
  input  logic                      cfg_enable,
  input  logic [7:0]                cfg_pulse_width,
  input  logic [7:0]                cfg_gap_cycles,
  output logic                      busy,
  output logic [31:0]               grant_count,
  output logic [31:0]               contention_count
);

  state_t                  state;
  logic [SRC_W-1:0]        rr_ptr;
  logic [HOLD_CNT_W-1:0]   hold_cnt;

  logic [NUM_REQ-1:0]      grant_oh;
  logic [SRC_W-1:0]        grant_idx;
  logic                    any_req;
  logic                    multi_req;
  logic                    grant_now;
  logic [DATA_W-1:0]       sel_data;
  logic [7:0]              eff_w;
  logic [HOLD_CNT_W-1:0]   hold_len;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant_oh),
    .grant_idx (grant_idx),
    .any_req   (any_req),
    .multi_req (multi_req)
  );

  assign grant_now = (state == ST_IDLE) && cfg_enable && any_req;
  assign req_ready = grant_now ? grant_oh : '0;
  assign busy      = (state == ST_HOLD);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == SRC_W'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Window spans the pulse, the trigger cycle and the guard gap; 10 bits cannot overflow.
  assign eff_w    = (cfg_pulse_width != 8'd0) ? cfg_pulse_width : 8'(PULSE_WIDTH_DEFAULT);
  assign hold_len = {2'b00, eff_w} + 10'd1 + {2'b00, cfg_gap_cycles};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      rr_ptr           <= '0;
      hold_cnt         <= '0;
      act_valid        <= 1'b0;
      act_data         <= '0;
      act_src          <= '0;
      grant_count      <= '0;
      contention_count <= '0;
    end else begin
      act_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_now) begin
            act_valid   <= 1'b1;
            act_data    <= sel_data;
            act_src     <= grant_idx;
            rr_ptr      <= (grant_idx == SRC_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
            grant_count <= grant_count + 32'd1;
            if (multi_req) contention_count <= contention_count + 32'd1;
            hold_cnt    <= hold_len;
            state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          hold_cnt <= hold_cnt - 1'b1;
          if (hold_cnt == HOLD_CNT_W'(1)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_action_scheduler.sv
// Directed-vector bench for action_scheduler with hand-computed expectations.
module tb_action_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;
  localparam int SRC_W   = 2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      act_valid;
  logic [DATA_W-1:0]         act_data;
  logic [SRC_W-1:0]          act_src;
  logic                      cfg_enable;
  logic [7:0]                cfg_pulse_width;
  logic [7:0]                cfg_gap_cycles;
  logic                      busy;
  logic [31:0]               grant_count;
  logic [31:0]               contention_count;

  int errors = 0;
  int checks = 0;

  action_scheduler #(
    .NUM_REQ             (NUM_REQ),
    .DATA_W              (DATA_W),
    .PULSE_WIDTH_DEFAULT (10)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .act_valid        (act_valid),
    .act_data         (act_data),
    .act_src          (act_src),
    .cfg_enable       (cfg_enable),
    .cfg_pulse_width  (cfg_pulse_width),
    .cfg_gap_cycles   (cfg_gap_cycles),
    .busy             (busy),
    .grant_count      (grant_count),
    .contention_count (contention_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    if (busy) chk("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 600) begin
      n++;
      tick();
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
  endtask

  int n;
  int bad;
  int g0;
  logic [3:0] exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    rst_n           = 1'b0;
    req_valid       = '0;
    req_data        = {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'hA0A0};
    cfg_enable      = 1'b1;
    cfg_pulse_width = 8'd0;
    cfg_gap_cycles  = 8'd2;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_act_valid", 32'(act_valid), 32'd0);
    chk("rst_act_data", 32'(act_data), 32'd0);
    chk("rst_act_src", 32'(act_src), 32'd0);
    chk("rst_grant_cnt", grant_count, 32'd0);
    chk("rst_cont_cnt", contention_count, 32'd0);
    rst_n = 1'b1;
    settle();
    chk("rst_ready", 32'(req_ready), 32'd0);

    // Single lane, default width, gap 2 -> H = 13
    req_valid = 4'b0100;
    settle();
    chk("single_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    chk("single_act_valid", 32'(act_valid), 32'd1);
    chk("single_act_src", 32'(act_src), 32'd2);
    chk("single_act_data", 32'(act_data), 32'hC2C2);
    n = 0;
    while (busy && n < 600) begin
      n++;
      tick();
      if (n == 1) chk("single_act_1cyc", 32'(act_valid), 32'd0);
    end
    chk("single_busy_len", 32'(n), 32'd13);
    chk("single_grant_cnt", grant_count, 32'd1);
    chk("single_cont_cnt", contention_count, 32'd0);

    // Rotation with all lanes valid, width 1 gap 0 -> H = 2
    pulse_reset();
    cfg_pulse_width = 8'd1;
    cfg_gap_cycles  = 8'd0;
    req_valid       = 4'b1111;
    settle();
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (req_ready == '0 && n < 20) begin
        tick();
        settle();
        n++;
      end
      if (k > 0) chk("rot_spacing", 32'(n), 32'd2);
      chk("rot_ready", 32'(req_ready), 32'(exp_order[k]));
      tick();
      chk("rot_act_valid", 32'(act_valid), 32'd1);
    end
    req_valid = '0;
    chk("rot_grant_cnt", grant_count, 32'd5);
    chk("rot_cont_cnt", contention_count, 32'd5);

    // Pointer wrap: grant lane 3, then lanes 0 and 3 together -> lane 0
    wait_idle(20);
    req_valid = 4'b1000;
    settle();
    chk("wrap_ready3", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    wait_idle(20);
    req_valid = 4'b1001;
    settle();
    chk("wrap_ready0", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    chk("wrap_act_src", 32'(act_src), 32'd0);
    chk("wrap_act_data", 32'(act_data), 32'hA0A0);

    // Config sampled only at the grant edge
    wait_idle(20);
    cfg_pulse_width = 8'd5;
    req_valid       = 4'b0010;
    settle();
    chk("samp_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid       = '0;
    cfg_pulse_width = 8'd100;
    count_busy(n);
    chk("samp_hold_5", 32'(n), 32'd6);
    req_valid = 4'b0010;
    settle();
    chk("samp_ready2", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    count_busy(n);
    chk("samp_hold_100", 32'(n), 32'd101);

    // Disable holds the request pending
    cfg_pulse_width = 8'd1;
    cfg_enable      = 1'b0;
    req_valid       = 4'b0001;
    g0  = grant_count;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      settle();
      if (req_ready != '0 || act_valid) bad++;
      tick();
    end
    chk("dis_quiet", 32'(bad), 32'd0);
    chk("dis_no_count", grant_count, 32'(g0));
    cfg_enable = 1'b1;
    settle();
    chk("dis_ready_same", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    chk("dis_act_valid", 32'(act_valid), 32'd1);
    chk("dis_grant_cnt", grant_count, 32'(g0 + 1));

    // Withdrawn request is not counted
    wait_idle(20);
    cfg_enable = 1'b0;
    req_valid  = 4'b0100;
    tick();
    req_valid  = '0;
    cfg_enable = 1'b1;
    tick();
    chk("withdraw_cnt", grant_count, 32'(g0 + 1));

    // Reset in the 3rd hold cycle
    cfg_pulse_width = 8'd0;
    cfg_gap_cycles  = 8'd2;
    req_valid       = 4'b0100;
    settle();
    tick();
    req_valid = '0;
    tick();
    tick();
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    settle();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_grant_cnt", grant_count, 32'd0);
    chk("mid_rst_cont_cnt", contention_count, 32'd0);
    chk("mid_rst_act_valid", 32'(act_valid), 32'd0);
    tick();
    rst_n     = 1'b1;
    req_valid = 4'b0010;
    settle();
    chk("post_rst_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    chk("post_rst_act_src", 32'(act_src), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
